// File: rtl/gpio_debounce_pkg.sv
// Shared types for the GPIO input debouncer.
package gpio_debounce_pkg;

   // Edge event committed by one pin's debouncer in a given clock.
   typedef enum logic [1:0] {
      EV_NONE = 2'd0,
      EV_RISE = 2'd1,
      EV_FALL = 2'd2
   } edge_e;

endpackage

// File: rtl/gpio_debounce_if.sv
// Pin-side and controller-side signals of the debouncer, grouped as one bus.
interface gpio_debounce_if #(
   parameter int NIN = 16
);
   logic [NIN-1:0] i_pins;
   logic [NIN-1:0] o_gpio;
   logic [NIN-1:0] o_rise;
   logic [NIN-1:0] o_fall;
   logic           o_changed;

   modport master (output i_pins, input o_gpio, o_rise, o_fall, o_changed);
   modport slave  (input i_pins, output o_gpio, o_rise, o_fall, o_changed);
endinterface

// File: rtl/gpio_debounce_bit.sv
// Single-pin debouncer: accepts a new level after NSAMPLES consecutive
// disagreeing sample ticks and emits a one-cycle edge strobe on commit.
module gpio_debounce_bit
   import gpio_debounce_pkg::*;
#(
   parameter int   NSAMPLES = 8,
   parameter logic DEFAULT  = 1'b0
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_tick,
   input  logic i_pin,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   localparam int            CW   = $clog2(NSAMPLES + 1);
   localparam logic [CW-1:0] LAST = CW'(NSAMPLES - 1);

   logic [CW-1:0] cnt;
   edge_e         ev;

   // Decide whether this tick commits a new level, and in which direction.
   always_comb begin
      ev = EV_NONE;
      if (i_tick && (i_pin != o_level) && (cnt == LAST))
         ev = i_pin ? EV_RISE : EV_FALL;
   end

   // Agreement counter, accepted level and registered strobes.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         cnt     <= '0;
         o_level <= DEFAULT;
         o_rise  <= 1'b0;
         o_fall  <= 1'b0;
      end else begin
         o_rise <= (ev == EV_RISE);
         o_fall <= (ev == EV_FALL);
         if (i_tick) begin
            if (i_pin == o_level) begin
               cnt <= '0;
            end else if (ev != EV_NONE) begin
               o_level <= i_pin;
               cnt     <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/gpio_debounce.sv
// Multi-pin input conditioner: synchronises raw pins, generates the sample
// tick and runs one debouncer per pin.
module gpio_debounce
   import gpio_debounce_pkg::*;
#(
   parameter int             NIN      = 16,
   parameter int             PRESCALE = 1000,
   parameter int             NSAMPLES = 8,
   parameter logic [NIN-1:0] DEFAULT  = '0
) (
   input  logic           i_clk,
   input  logic           i_reset,
   gpio_debounce_if.slave bus
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   (* ASYNC_REG = "TRUE" *) logic [NIN-1:0] sync_p0;
   (* ASYNC_REG = "TRUE" *) logic [NIN-1:0] s_pin;

   logic [PW-1:0]  presc;
   logic           tick;
   logic [NIN-1:0] gpio;
   logic [NIN-1:0] rise;
   logic [NIN-1:0] fall;

   // Two-flop synchroniser per pin; s_pin is the metastability-safe stage.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         sync_p0 <= DEFAULT;
         s_pin   <= DEFAULT;
      end else begin
         sync_p0 <= bus.i_pins;
         s_pin   <= sync_p0;
      end
   end

   // With PRESCALE=1 the compare value is 0 and the counter never leaves 0,
   // so the tick is permanently high.
   assign tick = (presc == PW'(PRESCALE - 1));

   // Free-running sample prescaler, wrapping on the tick.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)
         presc <= '0;
      else if (tick)
         presc <= '0;
      else
         presc <= presc + 1'b1;
   end

   for (genvar k = 0; k < NIN; k++) begin : g_pin
      gpio_debounce_bit #(
         .NSAMPLES (NSAMPLES),
         .DEFAULT  (DEFAULT[k])
      ) u_bit (
         .i_clk   (i_clk),
         .i_reset (i_reset),
         .i_tick  (tick),
         .i_pin   (s_pin[k]),
         .o_level (gpio[k]),
         .o_rise  (rise[k]),
         .o_fall  (fall[k])
      );
   end

   assign bus.o_gpio    = gpio;
   assign bus.o_rise    = rise;
   assign bus.o_fall    = fall;
   // Combines the per-pin strobe registers, so it pulses in the same cycle.
   assign bus.o_changed = |(rise | fall);

endmodule

// File: tb/tb_gpio_debounce.sv
// Directed bench for gpio_debounce: three instances cover PRESCALE=1,
// PRESCALE=10 and a non-zero DEFAULT.
module tb_gpio_debounce;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   gpio_debounce_if #(.NIN(16)) if_a ();
   gpio_debounce_if #(.NIN(16)) if_b ();
   gpio_debounce_if #(.NIN(16)) if_c ();

   gpio_debounce #(.NIN(16), .PRESCALE(1), .NSAMPLES(4), .DEFAULT(16'h0000))
      dut_a (.i_clk(clk), .i_reset(rst), .bus(if_a));
   gpio_debounce #(.NIN(16), .PRESCALE(10), .NSAMPLES(4), .DEFAULT(16'h0000))
      dut_b (.i_clk(clk), .i_reset(rst), .bus(if_b));
   gpio_debounce #(.NIN(16), .PRESCALE(1), .NSAMPLES(4), .DEFAULT(16'h0004))
      dut_c (.i_clk(clk), .i_reset(rst), .bus(if_c));

   typedef struct {
      logic [15:0] pins;
      logic [15:0] gpio;
      logic [15:0] rise;
      logic [15:0] fall;
      logic        changed;
   } vec_t;

   localparam int NVEC = 31;
   vec_t tbl [NVEC];

   int checks   = 0;
   int failures = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic check_rng(input string nm, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d..%0d", nm, act, lo, hi);
      end
   endtask

   task automatic fill(input int lo, input int hi, input logic [15:0] p, input logic [15:0] g,
                       input logic [15:0] r, input logic [15:0] f, input logic c);
      for (int i = lo; i <= hi; i++) begin
         tbl[i].pins    = p;
         tbl[i].gpio    = g;
         tbl[i].rise    = r;
         tbl[i].fall    = f;
         tbl[i].changed = c;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Holds reset for three clocks, checks the reset state, then releases.
   task automatic do_reset(input string nm);
      rst = 1'b1;
      repeat (3) step();
      check({nm, "_rst_gpio_a"}, if_a.o_gpio, 16'h0000);
      check({nm, "_rst_strb_a"}, {if_a.o_rise, if_a.o_fall, 15'd0, if_a.o_changed}, 48'd0);
      check({nm, "_rst_gpio_c"}, if_c.o_gpio, 16'h0004);
      rst = 1'b0;
   endtask

   int first, npulse, nchg, nfall;
   logic [15:0] rval, fval;

   initial begin
      if_a.i_pins = 16'h0000;
      if_b.i_pins = 16'h0000;
      if_c.i_pins = 16'h0004;
      #1;

      // Reset with all pins high: o_gpio follows after 6..7 clocks, one rise.
      if_a.i_pins = 16'hFFFF;
      do_reset("t1");
      first = -1; npulse = 0; nchg = 0; rval = '0;
      for (int n = 1; n <= 14; n++) begin
         step();
         if (first < 0 && if_a.o_gpio == 16'hFFFF) first = n;
         if (if_a.o_rise != 0) begin npulse++; rval = if_a.o_rise; end
         if (if_a.o_changed) nchg++;
      end
      check_rng("t1_latency", first, 6, 7);
      check("t1_rise_pulses", npulse, 1);
      check("t1_rise_value", rval, 16'hFFFF);
      check("t1_changed_pulses", nchg, 1);
      check("t1_c_idle", if_c.o_gpio, 16'h0004);

      // Simultaneous rise on pin 1 and fall on pin 2 (DEFAULT bit 2 = 1).
      if_c.i_pins = 16'h0002;
      first = -1; nchg = 0; rval = '0; fval = '0;
      for (int n = 1; n <= 14; n++) begin
         step();
         if (first < 0 && if_c.o_gpio == 16'h0002) first = n;
         if (if_c.o_changed) begin nchg++; rval = if_c.o_rise; fval = if_c.o_fall; end
      end
      check_rng("t5_latency", first, 6, 7);
      check("t5_changed_pulses", nchg, 1);
      check("t5_rise", rval, 16'h0002);
      check("t5_fall", fval, 16'h0004);

      // Cycle-exact vectors: short pulse, clean steps, multi-pin commit.
      fill(0, 2, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 1'b0);
      fill(3, 9, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
      fill(10, 14, 16'h0002, 16'h0000, 16'h0000, 16'h0000, 1'b0);
      fill(15, 15, 16'h0002, 16'h0002, 16'h0002, 16'h0000, 1'b1);
      fill(16, 16, 16'h0002, 16'h0002, 16'h0000, 16'h0000, 1'b0);
      fill(17, 21, 16'h0000, 16'h0002, 16'h0000, 16'h0000, 1'b0);
      fill(22, 22, 16'h0000, 16'h0000, 16'h0000, 16'h0002, 1'b1);
      fill(23, 23, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
      fill(24, 28, 16'h00F0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
      fill(29, 29, 16'h00F0, 16'h00F0, 16'h00F0, 16'h0000, 1'b1);
      fill(30, 30, 16'h00F0, 16'h00F0, 16'h0000, 16'h0000, 1'b0);
      if_a.i_pins = 16'h0000;
      do_reset("tv");
      repeat (3) step();
      for (int i = 0; i < NVEC; i++) begin
         if_a.i_pins = tbl[i].pins;
         step();
         check($sformatf("vec%0d_gpio", i), if_a.o_gpio, tbl[i].gpio);
         check($sformatf("vec%0d_rise", i), if_a.o_rise, tbl[i].rise);
         check($sformatf("vec%0d_fall", i), if_a.o_fall, tbl[i].fall);
         check($sformatf("vec%0d_changed", i), if_a.o_changed, tbl[i].changed);
      end

      // Pin 3 bounces 1,0,1,0 (two clocks each), then settles high.
      npulse = 0; nfall = 0;
      for (int b = 0; b < 4; b++) begin
         if_a.i_pins[3] = (b % 2 == 0);
         repeat (2) begin
            step();
            if (if_a.o_rise[3]) npulse++;
            if (if_a.o_fall[3]) nfall++;
         end
      end
      check("t2_gpio3_during_bounce", if_a.o_gpio[3], 1'b0);
      if_a.i_pins[3] = 1'b1;
      first = -1;
      for (int n = 1; n <= 14; n++) begin
         step();
         if (first < 0 && if_a.o_gpio[3]) first = n;
         if (if_a.o_rise[3]) npulse++;
         if (if_a.o_fall[3]) nfall++;
      end
      check_rng("t2_latency", first, 6, 7);
      check("t2_rise_pulses", npulse, 1);
      check("t2_fall_pulses", nfall, 0);

      // PRESCALE=10: pin 5 steps at reset release, commits on the 4th tick.
      if_b.i_pins = 16'h0000;
      do_reset("t4");
      if_b.i_pins = 16'h0020;
      first = -1; npulse = 0;
      for (int n = 1; n <= 60; n++) begin
         step();
         if (first < 0 && if_b.o_gpio[5]) first = n;
         if (if_b.o_rise[5]) npulse++;
      end
      check_rng("t4_latency", first, 38, 42);
      check("t4_rise_cycles", npulse, 1);
      check("t4_gpio", if_b.o_gpio, 16'h0020);

      // Reset while pin 7's count is 3 aborts the change; it restarts later.
      if_a.i_pins = 16'h0000;
      do_reset("t6");
      repeat (2) step();
      if_a.i_pins = 16'h0080;
      repeat (5) step();
      check("t6_gpio_before_abort", if_a.o_gpio[7], 1'b0);
      rst = 1'b1;
      #1;
      check("t6_gpio_in_reset", if_a.o_gpio[7], 1'b0);
      step();
      check("t6_gpio_after_edge", if_a.o_gpio[7], 1'b0);
      check("t6_strobe_in_reset", {if_a.o_rise[7], if_a.o_changed}, 2'b00);
      rst = 1'b0;
      first = -1; npulse = 0;
      for (int n = 1; n <= 14; n++) begin
         step();
         if (first < 0 && if_a.o_gpio[7]) first = n;
         if (if_a.o_rise[7]) npulse++;
      end
      check_rng("t6_fresh_latency", first, 6, 7);
      check("t6_rise_pulses", npulse, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
